// File: rtl/njp_micro_div.sv
// Sequential restoring divider: one quotient bit per cycle, shift-subtract datapath.
// Optional early exit for dividend < divisor when NJP_DIV_EARLY_EXIT_EN is defined.
module njp_micro_div #(
    parameter int DVD_W = 8,
    parameter int DVS_W = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CNT_W    = (DVD_W > 1) ? $clog2(DVD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DVD_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DVD_W-1:0]  q_q, q_d;
    // The partial remainder stays below the divisor after every restoring step,
    // so the extra bit only exists in the trial value, never in the stored register.
    logic [DVS_W-1:0]  r_q, r_d;
    logic [DVS_W-1:0]  d_q, d_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DVD_W-1:0]  quot_q, quot_d;
    logic [DVS_W-1:0]  rem_q, rem_d;
    logic              dbz_q, dbz_d;

    logic [DVS_W:0]    trial;
    logic              fits;
    logic [DVD_W-1:0]  q_shift;
    logic [DVS_W-1:0]  r_next;

    assign trial   = {r_q, q_q[DVD_W-1]};
    assign fits    = (trial >= {1'b0, d_q});
    assign q_shift = (q_q << 1) | DVD_W'(fits);
    assign r_next  = fits ? DVS_W'(trial - {1'b0, d_q}) : trial[DVS_W-1:0];

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_d   = dividend;
                    r_d   = '0;
                    d_d   = divisor;
                    cnt_d = CNT_LAST;
                    if (divisor == '0) begin
                        state_d = ST_DONE;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                    end
`ifdef NJP_DIV_EARLY_EXIT_EN
                    else if (dividend < DVD_W'(divisor)) begin
                        state_d = ST_DONE;
                        quot_d  = '0;
                        rem_d   = dividend[DVS_W-1:0];
                        dbz_d   = 1'b0;
                    end
`endif
                    else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                q_d   = q_shift;
                r_d   = r_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    quot_d  = q_shift;
                    rem_d   = r_next;
                    dbz_d   = 1'b0;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only; the working
    // registers are reset too so an aborted division leaves no stale operands.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_njp_micro_div.sv
// Scoreboard bench for njp_micro_div: stimulus pushes expected results with their
// due cycle; a negedge monitor checks every done pulse against the queue head.
module tb_njp_micro_div;

    localparam int DVD_W = 8;
    localparam int DVS_W = 4;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             div_by_zero;

    njp_micro_div #(.DVD_W(DVD_W), .DVS_W(DVS_W)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks    = 0;
    int errors    = 0;
    int issued    = 0;
    int done_seen = 0;

    typedef struct {
        logic [DVD_W-1:0] q;
        logic [DVS_W-1:0] r;
        logic             dbz;
        int               due;
        logic [DVD_W-1:0] dvd;
        logic [DVS_W-1:0] dvs;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division plus the documented latencies.
    function automatic exp_t model(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b, input int k);
        exp_t e;
        int   ai;
        int   bi;
        ai    = int'(a);
        bi    = int'(b);
        e.dvd = a;
        e.dvs = b;
        if (bi == 0) begin
            e.q   = '1;
            e.r   = '0;
            e.dbz = 1'b1;
            e.due = k + 1;
        end else begin
            e.q   = DVD_W'(ai / bi);
            e.r   = DVS_W'(ai % bi);
            e.dbz = 1'b0;
            e.due = k + DVD_W + 1;
`ifdef NJP_DIV_EARLY_EXIT_EN
            if (ai < bi) e.due = k + 1;
`endif
        end
        return e;
    endfunction

    always @(negedge sys_clk) begin : monitor
        exp_t e;
        logic exp_done;
        if (!sys_rst) begin
            while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
            exp_done = (sb.size() > 0) && (sb[0].due == cyc);
            check("done_pulse", 32'(done), 32'(exp_done));
            if (done && exp_done) begin
                e = sb.pop_front();
                done_seen++;
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                if (e.dvs != '0) begin
                    check("invariant", 32'(quotient) * 32'(e.dvs) + 32'(remainder), 32'(e.dvd));
                    check("rem_below_dvs", 32'(remainder < e.dvs), 32'd1);
                end
            end
        end
    end

    task automatic issue(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b);
        logic [31:0] rnd;
        @(negedge sys_clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b, cyc));
        issued++;
        @(negedge sys_clk);
        start    = 1'b0;
        rnd      = $urandom;
        dividend = rnd[7:0];
        divisor  = rnd[11:8];
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        #1;
        while (sb.size() != 0 && n < 40) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int off;
        int idx;
        sys_rst  = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge sys_clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        sys_rst = 1'b0;

        // 200/7 with busy window k+1..k+9
        issue(8'd200, 4'd7);
        check("busy_run", 32'(busy), 32'd1);
        for (int i = 2; i <= DVD_W + 1; i++) begin
            @(negedge sys_clk);
            check("busy_run", 32'(busy), 32'd1);
        end
        @(negedge sys_clk);
        #1;
        check("busy_idle", 32'(busy), 32'd0);
        wait_done();

        issue(8'd255, 4'd1);  wait_done();
        issue(8'd0, 4'd15);   wait_done();
        issue(8'd13, 4'd0);   wait_done();
        issue(8'd8, 4'd2);    wait_done();
        issue(8'd5, 4'd9);    wait_done();

        // start while busy must be ignored, not queued
        issue(8'd200, 4'd7);
        repeat (3) @(negedge sys_clk);
        start    = 1'b1;
        dividend = 8'd10;
        divisor  = 4'd3;
        @(negedge sys_clk);
        start = 1'b0;
        wait_done();
        repeat (12) @(negedge sys_clk);
        check("done_count_ignored_start", 32'(done_seen), 32'(issued));

        // reset mid-run aborts without a done pulse
        issue(8'd200, 4'd7);
        repeat (4) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        sb.delete();
        issued--;
        #1;
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (10) @(negedge sys_clk);
        issue(8'd100, 4'd10); wait_done();

        // every operand pair, in a random permutation with random idle gaps
        off = int'($urandom_range(4095, 0));
        for (int i = 0; i < 4096; i++) begin
            idx = (i * 1723 + off) % 4096;
            issue(DVD_W'(idx >> 4), DVS_W'(idx & 15));
            wait_done();
            repeat ($urandom_range(1, 0)) @(negedge sys_clk);
        end

        repeat (12) @(negedge sys_clk);
        check("done_count", 32'(done_seen), 32'(issued));
        check("queue_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
